// File: rtl/sc_stream_accum_if.sv
// Stream interface of the stochastic-to-binary accumulator: run request, bitstream in, run status and count out.
// Carries resultBi (bipolar decode) only when SC_STREAM_ACCUM_BIPOLAR_EN is defined.
interface sc_stream_accum_if #(
  parameter int WIDTH = 8
);
  // start is a request, accepted only while the accumulator is idle or in its done cycle
  // (busy=0); start seen while busy=1 is dropped, never queued. bitIn carries one bit per cycle
  // with no handshake. done is a one-cycle pulse; result/sat (and resultBi) are valid from that
  // cycle and hold until the next done.
  logic             start;
  logic             bitIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             sat;
`ifdef SC_STREAM_ACCUM_BIPOLAR_EN
  logic signed [WIDTH+1:0] resultBi;

  modport master (output start, bitIn, input busy, done, result, sat, resultBi);
  modport slave  (input start, bitIn, output busy, done, result, sat, resultBi);
`else
  modport master (output start, bitIn, input busy, done, result, sat);
  modport slave  (input start, bitIn, output busy, done, result, sat);
`endif
endinterface

// File: rtl/sc_stream_accum.sv
// Converts an SC divider quotient bitstream to binary: skips WARMUP cycles, then counts ones over 2^WIDTH cycles.
// Optional bipolar decode output enabled by defining SC_STREAM_ACCUM_BIPOLAR_EN.
module sc_stream_accum #(
  parameter int WIDTH  = 8,
  parameter int WARMUP = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sc_stream_accum_if.slave     s,
  output logic [1:0]           dbg_state
);

  localparam int PW = (WIDTH > $clog2(WARMUP + 1)) ? WIDTH : $clog2(WARMUP + 1);
  localparam logic [PW-1:0]  CNT_LAST  = PW'(2 ** WIDTH - 1);
  localparam logic [PW-1:0]  WARM_LAST = PW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [WIDTH:0] FULL      = {1'b1, {WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_COUNT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   ones_q, ones_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sat_q, sat_d;
`ifdef SC_STREAM_ACCUM_BIPOLAR_EN
  // Two extra bits so that both -2^WIDTH and +2^WIDTH are representable.
  logic signed [WIDTH+1:0] bi_q, bi_d;
`endif

  always_comb begin
    state_d  = state_q;
    ones_d   = ones_q;
    phase_d  = phase_q;
    result_d = result_q;
    sat_d    = sat_q;
`ifdef SC_STREAM_ACCUM_BIPOLAR_EN
    bi_d     = bi_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (s.start) begin
          state_d = (WARMUP > 0) ? S_WARM : S_COUNT;
          ones_d  = '0;
          phase_d = '0;
        end
      end
      S_WARM: begin
        if (phase_q == WARM_LAST) begin
          state_d = S_COUNT;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_COUNT: begin
        // bitIn only enters the datapath here, so X outside the window cannot reach the count.
        ones_d  = ones_q + {{WIDTH{1'b0}}, s.bitIn};
        phase_d = phase_q + PW'(1);
        if (phase_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = (ones_d == FULL) ? '1 : ones_d[WIDTH-1:0];
          sat_d    = (ones_d == FULL);
`ifdef SC_STREAM_ACCUM_BIPOLAR_EN
          bi_d     = $signed({ones_d, 1'b0} - {2'b01, {WIDTH{1'b0}}});
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ones_q   <= '0;
      phase_q  <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
`ifdef SC_STREAM_ACCUM_BIPOLAR_EN
      bi_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ones_q   <= ones_d;
      phase_q  <= phase_d;
      result_q <= result_d;
      sat_q    <= sat_d;
`ifdef SC_STREAM_ACCUM_BIPOLAR_EN
      bi_q     <= bi_d;
`endif
    end
  end

  assign s.busy    = (state_q == S_WARM) || (state_q == S_COUNT);
  assign s.done    = (state_q == S_DONE);
  assign s.result  = result_q;
  assign s.sat     = sat_q;
`ifdef SC_STREAM_ACCUM_BIPOLAR_EN
  assign s.resultBi = bi_q;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sc_stream_accum.sv
// Bench for sc_stream_accum: two instances (WARMUP=4 and WARMUP=0, WIDTH=4) share one directed stimulus
// and are checked every cycle against a window-arithmetic model, plus literal expectations per scenario.
module tb_sc_stream_accum;
  localparam int W = 4;
  localparam int N = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic start_i, bit_i;
  logic [1:0] dbg_a, dbg_b;

  sc_stream_accum_if #(.WIDTH(W)) if_a ();
  sc_stream_accum_if #(.WIDTH(W)) if_b ();

  assign if_a.start = start_i;
  assign if_a.bitIn = bit_i;
  assign if_b.start = start_i;
  assign if_b.bitIn = bit_i;

  sc_stream_accum #(.WIDTH(W), .WARMUP(4)) dut_a (
    .clk(clk), .rst(rst), .s(if_a.slave), .dbg_state(dbg_a));
  sc_stream_accum #(.WIDTH(W), .WARMUP(0)) dut_b (
    .clk(clk), .rst(rst), .s(if_b.slave), .dbg_state(dbg_b));

  logic         obs_busy[2];
  logic         obs_done[2];
  logic         obs_sat[2];
  logic [W-1:0] obs_res[2];
  assign obs_busy[0] = if_a.busy;   assign obs_busy[1] = if_b.busy;
  assign obs_done[0] = if_a.done;   assign obs_done[1] = if_b.done;
  assign obs_sat[0]  = if_a.sat;    assign obs_sat[1]  = if_b.sat;
  assign obs_res[0]  = if_a.result; assign obs_res[1]  = if_b.result;
`ifdef SC_STREAM_ACCUM_BIPOLAR_EN
  int obs_bi[2];
  assign obs_bi[0] = int'(if_a.resultBi);
  assign obs_bi[1] = int'(if_b.resultBi);
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard model: a run accepted at cycle t is busy for t+1..t+wu+N, done at t+wu+N+1,
  // and reports the ones among bits at cycles t+wu+1..t+wu+N
  int    wu[2]    = '{4, 0};
  int    run_t[2] = '{-1, -1};
  int    res_e[2] = '{0, 0};
  int    sat_e[2] = '{0, 0};
  int    bi_e[2]  = '{0, 0};
  string nm[2]    = '{"a", "b"};
  logic  hist[0:4095];
  bit    seen_rst = 1'b0;

  always @(negedge clk) begin
    bit busy_e, done_e;
    int ssum;
    for (int i = 0; i < 2; i++) begin
      busy_e = (run_t[i] >= 0) && (cyc >= run_t[i] + 1) && (cyc <= run_t[i] + wu[i] + N);
      done_e = (run_t[i] >= 0) && (cyc == run_t[i] + wu[i] + N + 1);
      if (done_e) begin
        ssum = 0;
        for (int k = run_t[i] + wu[i] + 1; k <= run_t[i] + wu[i] + N; k++)
          if (hist[k] === 1'b1) ssum++;
        res_e[i] = (ssum == N) ? N - 1 : ssum;
        sat_e[i] = (ssum == N) ? 1 : 0;
        bi_e[i]  = 2 * ssum - N;
        run_t[i] = -1;
      end
      if (seen_rst) begin
        check({nm[i], ".busy"},   int'(obs_busy[i]), int'(busy_e));
        check({nm[i], ".done"},   int'(obs_done[i]), int'(done_e));
        check({nm[i], ".result"}, int'(obs_res[i]),  res_e[i]);
        check({nm[i], ".sat"},    int'(obs_sat[i]),  sat_e[i]);
`ifdef SC_STREAM_ACCUM_BIPOLAR_EN
        check({nm[i], ".resultBi"}, obs_bi[i], bi_e[i]);
`endif
      end
      if (rst) begin
        run_t[i] = -1;
        res_e[i] = 0;
        sat_e[i] = 0;
        bi_e[i]  = 0;
      end else if (start_i && !busy_e) begin
        run_t[i] = cyc;
      end
    end
    if (cyc < 4096) hist[cyc] = bit_i;
    if (rst) seen_rst = 1'b1;
  end

  // driver
  int   dn_cnt[2];
  int   dn_off[2][4];
  int   dn_res[2][4];
  int   dn_sat[2][4];
  int   dn_bi[2][4];
  bit   busy_gap;
  int   rr_busy, rr_res, rr_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic bit_for(input int mode, input int off);
    case (mode)
      0:       return 1'b1;
      1:       return (off >= 1 && off <= 4) ? 1'b1 : 1'b0;
      2:       return (off >= 1 && (off % 2) == 1) ? 1'b1 : 1'b0;
      3:       return (off == 0 || off >= 21) ? 1'bx : 1'b1;
      4:       return (off <= 21) ? 1'b1 : 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  // Starts at the current cycle t (off=0); start is held for off<=hold, rst pulsed at rst_off.
  task automatic run_scn(input int mode, input int hold, input int rst_off, input int ncyc);
    for (int i = 0; i < 2; i++) dn_cnt[i] = 0;
    busy_gap = 1'b0;
    rr_busy = -1; rr_res = -1; rr_done = -1;
    for (int off = 0; off < ncyc; off++) begin
      if (off > 0) tick();
      for (int i = 0; i < 2; i++) begin
        if (obs_done[i] && dn_cnt[i] < 4) begin
          dn_off[i][dn_cnt[i]] = off;
          dn_res[i][dn_cnt[i]] = int'(obs_res[i]);
          dn_sat[i][dn_cnt[i]] = int'(obs_sat[i]);
`ifdef SC_STREAM_ACCUM_BIPOLAR_EN
          dn_bi[i][dn_cnt[i]]  = obs_bi[i];
`else
          dn_bi[i][dn_cnt[i]]  = 0;
`endif
          dn_cnt[i]++;
        end
      end
      if (off >= 1 && off <= 20 && !obs_busy[0]) busy_gap = 1'b1;
      if (off == rst_off + 1) begin
        rr_busy = int'(obs_busy[0]);
        rr_res  = int'(obs_res[0]);
        rr_done = int'(obs_done[0]);
      end
      start_i = (off <= hold);
      bit_i   = bit_for(mode, off);
      rst     = (off == rst_off);
    end
    tick();
    start_i = 1'b0;
    bit_i   = 1'b0;
    rst     = 1'b0;
    tick();
  endtask

  task automatic check_done(input string name, input int i, input int idx,
                            input int exp_off, input int exp_res, input int exp_sat);
    check({name, ".count"}, dn_cnt[i] > idx ? 1 : 0, 1);
    if (dn_cnt[i] > idx) begin
      check({name, ".latency"}, dn_off[i][idx], exp_off);
      check({name, ".result"},  dn_res[i][idx], exp_res);
      check({name, ".sat"},     dn_sat[i][idx], exp_sat);
    end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; bit_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset.busy",   int'(if_a.busy),   0);
    check("reset.done",   int'(if_a.done),   0);
    check("reset.result", int'(if_a.result), 0);
    check("reset.sat",    int'(if_a.sat),    0);

    run_scn(0, 0, -5, 30);
    check_done("ones_a", 0, 0, 21, 15, 1);
    check_done("ones_b", 1, 0, 17, 15, 1);
`ifdef SC_STREAM_ACCUM_BIPOLAR_EN
    check("ones_a.bi", dn_bi[0][0], 16);
`endif

    run_scn(1, 0, -5, 30);
    check_done("warm_a", 0, 0, 21, 0, 0);
    check_done("warm_b", 1, 0, 17, 4, 0);
`ifdef SC_STREAM_ACCUM_BIPOLAR_EN
    check("warm_a.bi", dn_bi[0][0], -16);
`endif

    run_scn(2, 0, -5, 30);
    check_done("alt_a", 0, 0, 21, 8, 0);
    check_done("alt_b", 1, 0, 17, 8, 0);
`ifdef SC_STREAM_ACCUM_BIPOLAR_EN
    check("alt_b.bi", dn_bi[1][0], 0);
`endif

    run_scn(0, 20, -5, 45);
    check("restart_a.ndone", dn_cnt[0], 1);
    check_done("restart_a", 0, 0, 21, 15, 1);
    check("restart_a.busy_gap", int'(busy_gap), 0);
    check("restart_b.ndone", dn_cnt[1], 2);

    run_scn(0, 0, 10, 30);
    check("abort_a.ndone", dn_cnt[0], 0);
    check("abort_b.ndone", dn_cnt[1], 0);
    check("abort_a.busy",   rr_busy, 0);
    check("abort_a.result", rr_res,  0);
    check("abort_a.done",   rr_done, 0);

    run_scn(2, 0, -5, 30);
    check_done("fresh_a", 0, 0, 21, 8, 0);

    run_scn(4, 21, -5, 50);
    check("b2b_a.ndone", dn_cnt[0], 2);
    check_done("b2b_a1", 0, 0, 21, 15, 1);
    check_done("b2b_a2", 0, 1, 42, 0, 0);
    check_done("b2b_b2", 1, 1, 34, 4, 0);

    run_scn(3, 0, -5, 30);
    check_done("xtol_a", 0, 0, 21, 15, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
